// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a registered one-hot
// grant. The owner keeps the grant while it requests; under contention it is
// rotated away after MAX_HOLD consecutive cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner, all grant outputs zero
// GRANT | gnt_idx owns the resource, hold counter tracks tenure
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_SAT = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_ptr;
    logic [1:0]    w_ptr_nxt;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic [3:0]    r_gnt;
    logic [3:0]    w_gnt_nxt;
    logic [CW-1:0] r_hold;
    logic [CW-1:0] w_hold_nxt;
    logic [3:0]    w_others;
    logic [1:0]    w_win;

    // First set bit of mask scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] mask);
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // Other pending requesters, excluding the current owner.
    assign w_others = req & ~(4'b0001 << r_idx);

    // Next-state, winner selection and hold counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_hold_nxt  = r_hold;
        w_win       = 2'd0;
        case (r_state)
            IDLE: begin
                if (req != 4'b0000) begin
                    w_win       = pick(r_ptr, req);
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_ptr_nxt   = w_win + 2'd1;
                end
            end
            GRANT: begin
                if (!req[r_idx] || (w_others != 4'b0000 && r_hold == HOLD_SAT)) begin
                    // Release or forced rotation: both hand off the same way.
                    if (w_others != 4'b0000) begin
                        w_win       = pick(r_idx + 2'd1, w_others);
                        w_idx_nxt   = w_win;
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = '0;
                        w_ptr_nxt   = w_win + 2'd1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = 2'd0;
                        w_valid_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if (r_hold != HOLD_SAT) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 2'd0;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // One-hot decode of the next owner so gnt is a register, not a decoder output.
    always_comb begin
        w_gnt_nxt = 4'b0000;
        if (w_valid_nxt) begin
            w_gnt_nxt[w_idx_nxt] = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_idx   <= 2'd0;
            r_valid <= 1'b0;
            r_gnt   <= 4'b0000;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_gnt   <= w_gnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=8; all expectations are hand-set
// one-hot grant constants, from which the expected index and valid are derived.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_checks;
    int n_errors;

    rr_arbiter4 #(.MAX_HOLD(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b (valid,idx,gnt)", tag, got, exp);
        end
    endtask

    // Expected {valid, idx, gnt} for a hand-chosen one-hot grant.
    function automatic logic [6:0] exp_of(input logic [3:0] g);
        case (g)
            4'b0001: exp_of = {1'b1, 2'd0, g};
            4'b0010: exp_of = {1'b1, 2'd1, g};
            4'b0100: exp_of = {1'b1, 2'd2, g};
            4'b1000: exp_of = {1'b1, 2'd3, g};
            default: exp_of = 7'b0;
        endcase
    endfunction

    task automatic chk_g(input string tag, input logic [3:0] g);
        chk(tag, {gnt_valid, gnt_idx, gnt}, exp_of(g));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    logic [3:0] seq [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        req = 4'b0000;
        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b0100;
        seq[3] = 4'b1000;
        repeat (2) tick();
        chk_g("reset_state", 4'b0000);
        rst = 1'b0;

        // Single requester held 20 cycles, no rotation, then clears.
        req = 4'b0100;
        tick();
        chk_g("single_first", 4'b0100);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk_g("single_hold", 4'b0100);
        end
        req = 4'b0000;
        tick();
        chk_g("single_drop", 4'b0000);

        // Reset asserted between edges while requester 2 owns the grant.
        req = 4'b0100;
        tick();
        chk_g("midrst_grant", 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk_g("midrst_async", 4'b0000);
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_g("contend_first", 4'b0001);

        // Full contention: each owner exactly 8 cycles, rotating 0,1,2,3,0.
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_g("contend_hold0", 4'b0001);
        end
        for (int o = 1; o < 4; o++) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                chk_g("contend_seq", seq[o]);
            end
        end
        tick();
        chk_g("contend_wrap", 4'b0001);

        // Early handoff with no dead cycle; new owner gets a fresh hold count.
        req = 4'b0000;
        do_reset();
        req = 4'b0011;
        tick();
        chk_g("early_own0", 4'b0001);
        tick();
        chk_g("early_own0", 4'b0001);
        tick();
        chk_g("early_own0", 4'b0001);
        req = 4'b0010;
        tick();
        chk_g("early_handoff", 4'b0010);
        req = 4'b0011;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_g("early_fresh_hold", 4'b0010);
        end
        tick();
        chk_g("early_rotate", 4'b0001);
        req = 4'b0000;
        tick();
        chk_g("early_release", 4'b0000);

        // Wrap fairness: after requester 3, pointer wraps to requester 0.
        do_reset();
        req = 4'b1000;
        tick();
        chk_g("wrap_own3", 4'b1000);
        req = 4'b0000;
        tick();
        chk_g("wrap_idle", 4'b0000);
        req = 4'b1001;
        tick();
        chk_g("wrap_pick0", 4'b0001);

        // Late contention after the hold counter has saturated.
        req = 4'b0000;
        do_reset();
        req = 4'b0010;
        tick();
        chk_g("late_own1", 4'b0010);
        for (int i = 1; i < 12; i++) begin
            tick();
            chk_g("late_alone", 4'b0010);
        end
        req = 4'b0110;
        tick();
        chk_g("late_rotate", 4'b0100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
